// File: rtl/vfifo_fwft_rd_ctrl.sv
// Read-side controller for a single-clock FIFO built on a dual-port RAM whose
// read port registers the address. Issues RAM reads ahead of the consumer and
// presents the returned words as a first-word-fall-through valid/ready stream
// through a 2-entry output buffer. The committed read pointer advances only
// when a word is actually latched, so the writer never reuses a slot early.
module vfifo_fwft_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH-1:0] adr_b,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH:0]   count,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    input  logic                  ready
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Pointers: iptr runs ahead (reads issued), rptr trails (words captured).
    logic [ADDR_WIDTH:0]   iptr_q;
    logic [ADDR_WIDTH:0]   rptr_q;
    logic                  inflight_q;

    // Output buffer: head_q is the oldest entry and drives dout directly.
    logic [1:0]            buf_cnt_q;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic                  valid_q;

    logic                  pop;
    logic                  capture;
    logic                  issue;
    logic [2:0]            occ_after_pop;

    logic [1:0]            buf_cnt_d;
    logic [DATA_WIDTH-1:0] head_d;
    logic [DATA_WIDTH-1:0] tail_d;

    assign pop     = valid_q & ready;
    assign capture = inflight_q;

    assign adr_b = iptr_q[ADDR_WIDTH-1:0];
    assign rptr  = rptr_q;
    assign count = wptr - rptr_q;
    assign dout  = head_q;
    assign valid = valid_q;

    // Issue a read when data is available and the buffer plus the word in
    // flight, after this cycle's pop, still leaves room for one more.
    always_comb begin
        occ_after_pop = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue         = (iptr_q != wptr) && (occ_after_pop < 3'd2);
    end

    // Next buffer contents for every capture/pop combination, keeping FIFO order.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        buf_cnt_d = buf_cnt_q;
        head_d    = head_q;
        tail_d    = tail_q;
        unique case ({capture, pop})
            2'b10: begin
                if (buf_cnt_q == 2'd0) head_d = ram_q;
                else                   tail_d = ram_q;
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b01: begin
                head_d    = tail_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b11: begin
                if (buf_cnt_q == 2'd1) begin
                    head_d = ram_q;
                end else begin
                    head_d = tail_q;
                    tail_d = ram_q;
                end
            end
            default: ;
        endcase
    end

    // State registers; a synchronous reset also discards any in-flight read.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            iptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            // NOTE: the two buffer words are plain registers, not RAM, so they
            // are cleared here to make dout read 0 out of reset.
            head_q     <= '0;
            tail_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            if (issue)   iptr_q <= iptr_q + PTR_ONE;
            if (capture) rptr_q <= rptr_q + PTR_ONE;
            inflight_q <= issue;
            buf_cnt_q  <= buf_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            valid_q    <= (buf_cnt_d != 2'd0);
        end
    end

endmodule

// File: tb/tb_vfifo_fwft_rd_ctrl.sv
// Bench for vfifo_fwft_rd_ctrl: a registered-read RAM model plus a scoreboard
// of words expected on the stream, in the order the writer made them visible.
module tb_vfifo_fwft_rd_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic [AW:0]   wptr;
    logic [AW-1:0] adr_b;
    logic [DW-1:0] ram_q;
    logic [AW:0]   rptr;
    logic [AW:0]   count;
    logic [DW-1:0] dout;
    logic          valid;
    logic          ready;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] sb_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    vfifo_fwft_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .wptr  (wptr),
        .adr_b (adr_b),
        .ram_q (ram_q),
        .rptr  (rptr),
        .count (count),
        .dout  (dout),
        .valid (valid),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM read port with a registered address: data one cycle after adr_b.
    always @(posedge clk) ram_q <= mem[adr_b];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Every accepted word must be the oldest word still owed to the consumer.
    always @(negedge clk) begin
        if (rst === 1'b0 && valid === 1'b1 && ready === 1'b1) begin
            if (sb_q.size() == 0) check("unexpected_word", {24'd0, dout}, 32'hFFFF_FFFF);
            else check("stream_dout", {24'd0, dout}, {24'd0, sb_q.pop_front()});
        end
    end

    // Start a new cycle: just after the rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst  = 1'b1;
        wptr = '0;
        sb_q.delete();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        @(negedge clk);
        while (valid !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, valid}, 32'd1);
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while ((sb_q.size() != 0 || valid !== 1'b0) && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, (sb_q.size() == 0 && valid === 1'b0)}, 32'd1);
    endtask

    // Make words visible from pointer 'from' up to (not including) 'to'.
    task automatic publish(input logic [AW:0] from, input logic [AW:0] to);
        logic [AW:0] p = from;
        while (p != to) begin
            sb_q.push_back(mem[p[AW-1:0]]);
            p = p + 1'b1;
        end
        wptr = to;
    endtask

    initial begin
        logic [4:0] exp_adr  [6];
        logic [4:0] exp_rptr [6];

        rst   = 1'b1;
        wptr  = '0;
        ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // 1. Reset held two cycles, then idle with nothing written.
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_rptr",  {27'd0, rptr},  32'd0);
        check("rst_adr_b", {28'd0, adr_b}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_dout",  {24'd0, dout},  32'd0);
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            @(negedge clk);
            check("idle_valid", {31'd0, valid}, 32'd0);
            check("idle_adr_b", {28'd0, adr_b}, 32'd0);
        end

        // 2. Single word: visible two cycles after wptr moves.
        mem[0] = 8'hA5;
        cyc();
        publish(5'd0, 5'd1);
        @(negedge clk);
        check("single_adr_k", {28'd0, adr_b}, 32'd0);
        check("single_count_k", {27'd0, count}, 32'd1);
        cyc();
        @(negedge clk);
        check("single_valid_k1", {31'd0, valid}, 32'd0);
        cyc();
        @(negedge clk);
        check("single_valid_k2", {31'd0, valid}, 32'd1);
        check("single_dout_k2",  {24'd0, dout},  32'hA5);
        check("single_rptr_k2",  {27'd0, rptr},  32'd1);
        cyc();
        @(negedge clk);
        check("single_valid_k3", {31'd0, valid}, 32'd0);

        // 3. Full-depth stream with ready high: 16 gapless words.
        for (int i = 0; i < 16; i++) mem[i] = DW'(i);
        do_reset();
        publish(5'd0, 5'd16);
        wait_valid("stream_start", 10);
        for (int i = 0; i < 16; i++) begin
            check("stream_valid", {31'd0, valid}, 32'd1);
            cyc();
            @(negedge clk);
        end
        check("stream_end_valid", {31'd0, valid}, 32'd0);
        check("stream_end_rptr",  {27'd0, rptr},  32'd16);
        check("stream_end_count", {27'd0, count}, 32'd0);

        // 4. Backpressure: only two words pulled while the consumer stalls.
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        do_reset();
        ready = 1'b0;
        publish(5'd0, 5'd3);
        repeat (6) @(negedge clk);
        check("bp_rptr",  {27'd0, rptr},  32'd2);
        check("bp_adr_b", {28'd0, adr_b}, 32'd2);
        check("bp_count", {27'd0, count}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid_hold", {31'd0, valid}, 32'd1);
            check("bp_dout_hold",  {24'd0, dout},  32'h11);
            cyc();
            @(negedge clk);
        end
        cyc();
        ready = 1'b1;
        @(negedge clk);
        check("bp_rel_0", {24'd0, dout}, 32'h11);
        cyc();
        @(negedge clk);
        check("bp_rel_1", {24'd0, dout}, 32'h22);
        cyc();
        @(negedge clk);
        check("bp_rel_2",  {24'd0, dout}, 32'h33);
        check("bp_rptr_3", {27'd0, rptr}, 32'd3);
        cyc();
        @(negedge clk);
        check("bp_done_valid", {31'd0, valid}, 32'd0);

        // 5. Pointer and address wrap.
        for (int i = 0; i < 16; i++) mem[i] = 8'h50 + DW'(i);
        do_reset();
        publish(5'd0, 5'd15);
        drain("wrap_pre_drain_a", 60);
        cyc();
        publish(5'd15, 5'd30);
        drain("wrap_pre_drain_b", 60);
        check("wrap_pre_rptr",  {27'd0, rptr},  32'd30);
        check("wrap_pre_adr_b", {28'd0, adr_b}, 32'd14);
        mem[14] = 8'hC0;
        mem[15] = 8'hC1;
        mem[0]  = 8'hC2;
        mem[1]  = 8'hC3;
        exp_adr  = '{5'd14, 5'd15, 5'd0, 5'd1, 5'd2, 5'd2};
        exp_rptr = '{5'd30, 5'd30, 5'd31, 5'd0, 5'd1, 5'd2};
        cyc();
        publish(5'd30, 5'd2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("wrap_adr_b", {28'd0, adr_b}, {27'd0, exp_adr[i]});
            check("wrap_rptr",  {27'd0, rptr},  {27'd0, exp_rptr[i]});
            cyc();
        end
        drain("wrap_drain", 20);

        // 6. Reset mid-stream with a read in flight.
        for (int i = 0; i < 16; i++) mem[i] = 8'h40 + DW'(i);
        do_reset();
        publish(5'd0, 5'd16);
        wait_valid("mid_rst_start", 10);
        cyc();
        rst  = 1'b1;
        wptr = '0;
        sb_q.delete();
        @(negedge clk);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", {31'd0, valid}, 32'd0);
        check("mid_rst_rptr",  {27'd0, rptr},  32'd0);
        check("mid_rst_adr_b", {28'd0, adr_b}, 32'd0);
        check("mid_rst_dout",  {24'd0, dout},  32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge clk);
            check("mid_rst_quiet", {31'd0, valid}, 32'd0);
        end

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
